// File: rtl/opimm_pkg.sv
// Shared definitions for the OP-IMM issue stage: opcode, funct3 encodings
// and the operand bundle handed to the ALU.
package opimm_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] in1;
    logic [4:0]  rd;
  } opimm_bundle_t;

endpackage

// File: rtl/opimm_regfile.sv
// 31x32 integer register file: one write port, one read port with x0 forced
// to zero and write-through bypass of a same-cycle writeback.
module opimm_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  // x0 has no storage; entries 1..31 only.
  logic [31:0] mem [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      mem[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr != 5'd0) begin
      if (wb_en && (wb_rd == rd_addr)) begin
        rd_data = wb_data;
      end else begin
        rd_data = mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/opimm_issue_stage.sv
// OP-IMM issue stage: decodes and legality-checks instructions, reads rs1 and
// holds one registered operand bundle for the ALU; drops and counts illegals.
module opimm_issue_stage
  import opimm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [11:0]      out_imm,
  output logic [XLEN-1:0]  out_in1,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high; in_ready is free whenever the issue register is empty or drains now.
  assign in_ready = !out_valid || out_ready;

  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rs1;
  logic [11:0] dec_imm;
  logic        legal;
  logic        accept;
  logic [31:0] rs1_val;
  opimm_bundle_t bundle_q;

  assign dec_opcode = in_instr[6:0];
  assign dec_rd     = in_instr[11:7];
  assign dec_funct3 = in_instr[14:12];
  assign dec_rs1    = in_instr[19:15];
  assign dec_imm    = in_instr[31:20];

  // Shifts encode the shamt in imm[4:0]; the upper bits select SRLI/SRAI only.
  always_comb begin
    legal = (dec_opcode == OPC_OP_IMM);
    if (dec_funct3 == F3_SLLI) begin
      legal = legal && (dec_imm[11:5] == 7'b0000000);
    end else if (dec_funct3 == F3_SRXI) begin
      legal = legal && ((dec_imm[11:5] == 7'b0000000) ||
                        (dec_imm[11:5] == 7'b0100000));
    end
  end

  assign accept = in_valid && in_ready;

  opimm_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (dec_rs1),
    .rd_data (rs1_val),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= '0;
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= accept && !legal;
      if (accept && !legal && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
      if (accept && legal) begin
        bundle_q.opcode <= dec_opcode;
        bundle_q.funct3 <= dec_funct3;
        bundle_q.imm    <= dec_imm;
        bundle_q.in1    <= rs1_val;
        bundle_q.rd     <= dec_rd;
        out_valid       <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_opcode = bundle_q.opcode;
  assign out_funct3 = bundle_q.funct3;
  assign out_imm    = bundle_q.imm;
  assign out_in1    = bundle_q.in1;
  assign out_rd     = bundle_q.rd;

endmodule

// File: tb/tb_opimm_issue_stage.sv
// Bench for opimm_issue_stage: directed literal checks plus randomized traffic
// against a behavioural model; a CNT_W=2 twin shares inputs to test saturation.
module tb_opimm_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [11:0] out_imm;
  logic [31:0] out_in1;
  logic [4:0]  out_rd;
  logic        illegal;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_out_valid, s_illegal;
  logic [6:0]  s_opcode;
  logic [2:0]  s_funct3;
  logic [11:0] s_imm;
  logic [31:0] s_in1;
  logic [4:0]  s_rd;
  logic [1:0]  s_cnt;

  opimm_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_imm(out_imm), .out_in1(out_in1),
    .out_rd(out_rd), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  opimm_issue_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(s_in_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_opcode(s_opcode),
    .out_funct3(s_funct3), .out_imm(s_imm), .out_in1(s_in1),
    .out_rd(s_rd), .illegal(s_illegal), .illegal_cnt(s_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  bit          m_valid;
  logic [6:0]  m_opcode;
  logic [2:0]  m_funct3;
  logic [11:0] m_imm;
  logic [31:0] m_in1;
  logic [4:0]  m_rd;
  bit          m_illegal;
  int          m_cnt;

  function automatic bit is_legal(input logic [31:0] ins);
    logic [6:0] top;
    top = ins[31:25];
    if (ins[6:0] != 7'b0010011) return 1'b0;
    if (ins[14:12] == 3'b001) return top == 7'd0;
    if (ins[14:12] == 3'b101) return (top == 7'd0) || (top == 7'b0100000);
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_opcode = '0; m_funct3 = '0; m_imm = '0; m_in1 = '0; m_rd = '0;
    m_illegal = 0; m_cnt = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit acc;
      logic [4:0] rs1;
      logic [31:0] opnd;
      acc = in_valid && (!m_valid || out_ready);
      rs1 = in_instr[19:15];
      if (rs1 == 0) opnd = 0;
      else if (wb_en && wb_rd == rs1) opnd = wb_data;
      else opnd = m_rf[rs1];
      m_illegal = acc && !is_legal(in_instr);
      if (m_illegal) m_cnt++;
      if (acc && is_legal(in_instr)) begin
        m_valid = 1; m_opcode = in_instr[6:0]; m_funct3 = in_instr[14:12];
        m_imm = in_instr[31:20]; m_in1 = opnd; m_rd = in_instr[11:7];
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
      chk("illegal_cnt", {16'd0, illegal_cnt}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      chk("sat_cnt", {30'd0, s_cnt}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      if (m_valid) begin
        chk("out_opcode", {25'd0, out_opcode}, {25'd0, m_opcode});
        chk("out_funct3", {29'd0, out_funct3}, {29'd0, m_funct3});
        chk("out_imm", {20'd0, out_imm}, {20'd0, m_imm});
        chk("out_in1", out_in1, m_in1);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [4:0] rd);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Apply inputs for one cycle, then return 1ns after the rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic ordy);
    rst = r; in_valid = v; in_instr = ins; wb_en = we; wb_rd = wr; wb_data = wd;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    logic [2:0] f3;
    logic [11:0] imm;
    r = $urandom_range(0, 9);
    f3 = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (r < 7) begin
      if (f3 == 3'b001) imm[11:5] = 7'd0;
      if (f3 == 3'b101) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
      return mk(7'b0010011, f3, imm, 5'($urandom), 5'($urandom));
    end else if (r == 7) begin
      return mk(7'b0010011, ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101, imm,
                5'($urandom), 5'($urandom));
    end
    return $urandom;
  endfunction

  logic [31:0] hold_in1;
  logic [11:0] hold_imm;
  logic [4:0]  hold_rd;

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; wb_en = 0; wb_rd = '0; wb_data = '0;
    out_ready = 1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 1);
    cmp_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_in1", out_in1, 32'd0);
    chk("rst_out_rd_imm", {15'd0, out_opcode, out_imm}, 32'd0);
    chk("rst_illegal_cnt", {16'd0, illegal_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI rd=x5, rs1=x0, imm=7FF
    step(0, 1, mk(7'b0010011, 3'b000, 12'h7FF, 5'd0, 5'd5), 0, 0, 0, 1);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_in1", out_in1, 32'd0);
    chk("addi_imm", {20'd0, out_imm}, 32'h7FF);
    chk("addi_rd", {27'd0, out_rd}, 32'd5);
    chk("addi_f3", {29'd0, out_funct3}, 32'd0);
    chk("addi_opc", {25'd0, out_opcode}, 32'h13);

    // Same-cycle bypass of x3
    step(0, 1, mk(7'b0010011, 3'b110, 12'h001, 5'd3, 5'd6), 1, 5'd3, 32'hDEADBEEF, 1);
    chk("bypass_in1", out_in1, 32'hDEADBEEF);
    chk("bypass_f3", {29'd0, out_funct3}, 32'd6);
    step(0, 1, mk(7'b0010011, 3'b000, 12'h000, 5'd0, 5'd7), 1, 5'd0, 32'h1234, 1);
    chk("x0_read", out_in1, 32'd0);
    step(0, 1, mk(7'b0010011, 3'b100, 12'h0F0, 5'd3, 5'd8), 0, 0, 0, 1);
    chk("stored_x3", out_in1, 32'hDEADBEEF);

    // Backpressure
    hold_in1 = out_in1; hold_imm = out_imm; hold_rd = out_rd;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, mk(7'b0010011, 3'b111, 12'h055, 5'd3, 5'd9), 0, 0, 0, 0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {out_in1[19:0], out_imm}, {hold_in1[19:0], hold_imm});
      chk("bp_rd", {27'd0, out_rd}, {27'd0, hold_rd});
    end
    out_ready = 1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step(0, 1, mk(7'b0010011, 3'b111, 12'h055, 5'd3, 5'd9), 0, 0, 0, 1);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_rd", {27'd0, out_rd}, 32'd9);

    // Illegal inputs with the issue register empty
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, mk(7'b0110011, 3'b000, 12'h000, 5'd1, 5'd2), 0, 0, 0, 1);
    chk("ill1_pulse", {31'd0, illegal}, 32'd1);
    chk("ill1_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, mk(7'b0010011, 3'b001, 12'h021, 5'd1, 5'd2), 0, 0, 0, 1);
    chk("ill2_pulse", {31'd0, illegal}, 32'd1);
    chk("ill2_cnt", {16'd0, illegal_cnt}, 32'd2);
    chk("ill2_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, mk(7'b0010011, 3'b101, 12'h403, 5'd3, 5'd4), 0, 0, 0, 1);
    chk("srai_legal", {31'd0, out_valid}, 32'd1);
    chk("srai_no_pulse", {31'd0, illegal}, 32'd0);
    chk("srai_imm", {20'd0, out_imm}, 32'h403);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h0000_0033, 0, 0, 0, 1);
    chk("cnt5", {16'd0, illegal_cnt}, 32'd5);
    chk("sat3", {30'd0, s_cnt}, 32'd3);

    // Reset mid-operation with a pending writeback to x7
    step(0, 1, mk(7'b0010011, 3'b000, 12'h001, 5'd0, 5'd1), 0, 0, 0, 0);
    step(1, 1, mk(7'b0010011, 3'b000, 12'h002, 5'd0, 5'd1), 1, 5'd7, 32'hCAFE0001, 0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_cnt", {16'd0, illegal_cnt}, 32'd0);
    step(0, 1, mk(7'b0010011, 3'b000, 12'h000, 5'd7, 5'd1), 0, 0, 0, 1);
    chk("rst_x7", out_in1, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
           ($urandom_range(0, 1) == 1), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 7));
    end
    step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/opimm_issue_stage.md
# opimm_issue_stage

Issue stage directly upstream of the OP-IMM ALU. Accepts 32-bit instructions over a valid/ready handshake, decodes the OP-IMM fields and reads `rs1` from an internal 31×32 register file. Issues a registered operand bundle `(opcode, funct3, imm, in1, rd)` to the ALU. A writeback port from the downstream stage updates the register file, with same-cycle bypass to the read.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `CNT_W`, 16, width of the illegal-instruction counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the instruction on `in_instr` is valid.
- `in_instr`  in  32  RV32 instruction word.
- `in_ready`  out  1  the stage can accept an instruction this cycle.
- `wb_en`  in  1  writeback enable.
- `wb_rd`  in  5  writeback destination register.
- `wb_data`  in  32  writeback value.
- `out_valid`  out  1  the issue register holds a bundle.
- `out_ready`  in  1  the ALU consumes the bundle this cycle.
- `out_opcode`  out  7  bundle opcode; always 7'b0010011 when valid.
- `out_funct3`  out  3  bundle funct3.
- `out_imm`  out  12  bundle `instr[31:20]`.
- `out_in1`  out  32  `rs1` operand value.
- `out_rd`  out  5  destination register.
- `illegal`  out  1  one-cycle pulse when an accepted instruction is dropped.
- `illegal_cnt`  out  CNT_W  saturating count of dropped instructions.

## Operation
- Handshake: `in_ready = !out_valid || out_ready` (combinational). An instruction is accepted when `in_valid && in_ready`.
- Field extraction:
  - opcode = `[6:0]`
  - rd = `[11:7]`
  - funct3 = `[14:12]`
  - rs1 = `[19:15]`
  - imm = `[31:20]`
- Legality: opcode must be 7'b0010011.
  - funct3 001 additionally requires `imm[11:5] == 0`.
  - funct3 101 additionally requires `imm[11:5]` ∈ {7'b0000000, 7'b0100000}.
- A legal instruction is accepted into the issue register with the extracted fields and the operand read below.
- An illegal instruction is accepted and discarded:
  - The issue register is unchanged.
  - `illegal` pulses the following cycle.
  - `illegal_cnt` increments, saturating at all-ones.
- Operand read for `rs1`:
  - If `rs1 == 0`: the operand is 0.
  - Else if `wb_en && wb_rd == rs1`: the operand is `wb_data` (bypass).
  - Otherwise: the operand is the stored register value.
- Register file:
  - Write when `wb_en && wb_rd != 0`.
  - Writes to x0 are ignored; x0 has no storage.
- The operand is captured at accept. Later writebacks do not alter a bundle already held in the issue register.
- Issue register state:
  - `out_valid` sets on accepting a legal instruction.
  - `out_valid` clears when `out_ready` is high and no legal instruction is accepted in the same cycle.
  - If the bundle is consumed and a new legal instruction is accepted in the same cycle, the register reloads with `out_valid` staying high.
  - While `out_valid && !out_ready`, all `out_*` fields are held stable.
- No hazard detection beyond the same-cycle bypass. Scheduling distance is the pipeline's responsibility.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 instruction per cycle when `out_ready` is held high.
- `illegal` asserts exactly 1 cycle after the illegal accept and lasts 1 cycle.
- A register write is visible to a read in the next cycle through storage, and in the same cycle through bypass.
- Reset values:
  - `out_valid` = 0.
  - All `out_*` fields = 0.
  - `illegal` = 0.
  - `illegal_cnt` = 0.
  - All register-file entries = 0.
- `in_ready` is 1 in the first cycle after reset.
- Reset takes priority over everything else, including a simultaneous accept or writeback. It drops any in-flight bundle; the bundle is not replayed.

## Structure
- Shared package `opimm_pkg` holds:
  - `OPC_OP_IMM` = 7'b0010011.
  - funct3 constants: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRxI.
  - The `opimm_bundle_t` struct: opcode, funct3, imm, in1, rd.
- One sub-module, `opimm_regfile`:
  - One read port with the x0-zero and write-through bypass logic.
  - One write port.
  - Synchronous `rst` clears all entries.
- The top level holds decode, legality check, issue register and counter.

## Test plan
- Reset, then accept ADDI with rs1=x0, imm=12'h7FF, rd=x5.
  - Next cycle: `out_valid=1`, `out_in1=0`, `out_imm=12'h7FF`, `out_rd=5`, `out_funct3=000`.
- Bypass: in the same cycle, `wb_en=1`, `wb_rd=3`, `wb_data=32'hDEADBEEF` and accept ORI with rs1=x3.
  - Required: `out_in1=32'hDEADBEEF`.
  - Write `wb_rd=0` with `32'h1234`, then read x0. Required: `out_in1=0`.
- Backpressure: hold `out_ready=0` with a bundle held and `in_valid=1`.
  - Required: `in_ready=0` and `out_*` stable for 5 cycles.
  - Raise `out_ready`: the next bundle loads the following cycle with no bubble.
- Illegal inputs: send opcode 7'b0110011, then SLLI with `imm[11:5]=7'b0000001`.
  - Required: two `illegal` pulses, `illegal_cnt=2`, `out_valid` unchanged.
  - SRAI with `imm[11:5]=7'b0100000` is accepted as legal.
- Counter saturation: with `CNT_W=2`, send 5 illegal instructions.
  - Required: `illegal_cnt` saturates at 3.
- Reset mid-operation: assert `rst` for one cycle while `out_valid=1` and a writeback to x7 is pending.
  - Required: `out_valid=0` next cycle.
  - A subsequent read of x7 returns 0.
